// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Frame: start(0), DATA_W data bits LSB first, optional parity, stop(1).
// Every bit is held CLKS_PER_BIT cycles; tx, busy and done are flop outputs.
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bit;
  logic              last_cyc;

  // End of the current bit time; the next bit is loaded into tx on this edge.
  assign last_cyc = (cyc_cnt == CW'(CLKS_PER_BIT - 1));

  // Frame sequencer. tx is loaded one edge ahead so it is always a flop output;
  // the shift register is consumed as each data bit is placed on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            shift_reg <= tx_data;
            // parity comes from the latched copy, so later tx_data changes are harmless
            par_bit   <= (^tx_data) ^ (PARITY_ODD != 0);
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= START;
            busy      <= 1'b1;
            tx        <= 1'b0;
          end
        end
        default: begin
          if (!last_cyc) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end else begin
            cyc_cnt <= '0;
            case (state)
              START: begin
                state     <= DATA;
                bit_cnt   <= '0;
                tx        <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end
              DATA: begin
                if (bit_cnt == BW'(DATA_W - 1)) begin
                  if (PARITY_EN != 0) begin
                    state <= PARITY;
                    tx    <= par_bit;
                  end else begin
                    state <= STOP;
                    tx    <= 1'b1;
                  end
                end else begin
                  bit_cnt   <= bit_cnt + 1'b1;
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                end
              end
              PARITY: begin
                state <= STOP;
                tx    <= 1'b1;
              end
              STOP: begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                tx    <= 1'b1;
              end
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
                tx    <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
